// File: rtl/tty_ram_sched.sv
// Text-RAM access scheduler: arbitrates single character writes against bulk
// clear / scroll-up commands, issuing RAM accesses only while the window is open.
module tty_ram_sched #(
  parameter int          COLS = 128,
  parameter int          ROWS = 64,
  parameter logic [7:0]  FILL = 8'h20,
  localparam int         CW   = $clog2(COLS),
  localparam int         RW   = $clog2(ROWS),
  localparam int         AW   = CW + RW
) (
  input  logic          pixel2_clk,
  input  logic          irst,
  input  logic          win,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_data,
  output logic          req_ready,
  input  logic          cmd_valid,
  input  logic          cmd_op,
  output logic          cmd_ready,
  output logic          busy,
  output logic          done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCR_RD,
    SCR_WR,
    SCR_FILL
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    hold_q, hold_d;
  logic          rd_pend_q, rd_pend_d;

  logic          ptr_last;
  logic          row_end;

  assign ptr_last = (ptr_q == {AW{1'b1}});
  // Last column of the second-to-last row: after this copy only the fill row remains.
  assign row_end  = (ptr_q[CW-1:0] == {CW{1'b1}}) &&
                    (ptr_q[AW-1:CW] == RW'(ROWS - 2));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = rd_pend_q ? ram_dout : hold_q;
    rd_pend_d = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    req_ready = 1'b0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready = 1'b1;
          ptr_d     = '0;
          state_d   = cmd_op ? SCR_RD : CLEAR;
        end else if (req_valid && win) begin
          req_ready = 1'b1;
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = req_addr;
          ram_din   = req_data;
        end
      end
      CLEAR, SCR_FILL: begin
        if (win) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = ptr_q;
          ram_din  = FILL;
          if (ptr_last) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      SCR_RD: begin
        if (win) begin
          ram_en    = 1'b1;
          ram_addr  = ptr_q + AW'(COLS);
          rd_pend_d = 1'b1;
          state_d   = SCR_WR;
        end
      end
      SCR_WR: begin
        if (win) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = ptr_q;
          // Read data lands this cycle when the write directly follows the read.
          ram_din  = rd_pend_q ? ram_dout : hold_q;
          ptr_d    = ptr_q + 1'b1;
          state_d  = row_end ? SCR_FILL : SCR_RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output in the same cycle, aborting any bulk command.
    if (irst) begin
      state_d   = IDLE;
      ptr_d     = '0;
      hold_d    = '0;
      rd_pend_d = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      req_ready = 1'b0;
      cmd_ready = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge pixel2_clk) begin
    state_q   <= state_d;
    ptr_q     <= ptr_d;
    hold_q    <= hold_d;
    rd_pend_q <= rd_pend_d;
  end

endmodule
